// File: rtl/aclint_nhart_pkg.sv
// eei: shared memory-map constants plus ACLINT decode helpers.
//   XLEN                  bus address width
//   MMAP_ACLINT_*         ACLINT base address and register-block offsets
//   ACLINT_MAX_HARTS      upper bound for NUM_HARTS
//   aclint_reg_e          register block hit by a bus offset
//   byte_mask()           expands 8 byte enables into a 64-bit bit mask
package eei;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] MMAP_ACLINT_BEGIN    = 32'h0200_0000;
    localparam logic [XLEN-1:0] MMAP_ACLINT_MSIP     = 32'h0000_0000;
    localparam logic [XLEN-1:0] MMAP_ACLINT_MTIMECMP = 32'h0000_4000;
    localparam logic [XLEN-1:0] MMAP_ACLINT_MTIME    = 32'h0000_7ff8;
    localparam logic [XLEN-1:0] MMAP_ACLINT_SETSSIP  = 32'h0000_8000;

    localparam int ACLINT_MAX_HARTS = 32;

    typedef enum logic [2:0] {
        MSIP_R,
        MTIMECMP_R,
        MTIME_R,
        SETSSIP_R,
        NONE_R
    } aclint_reg_e;

    function automatic logic [63:0] byte_mask(input logic [7:0] en);
        logic [63:0] m;
        for (int i = 0; i < 8; i++) begin
            m[8*i +: 8] = {8{en[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/aclint_nhart_mtimer.sv
// aclint_mtimer: mtime prescaler, 64-bit mtime counter and per-hart timer
// compare.
//   clk, rst       clock, async active-low reset
//   mtime_we       bus write to mtime this cycle (wins over the tick)
//   mtime_wdata    already byte-merged value to load
//   mtimecmp       NUM_HARTS x 64-bit compare values, hart h at [64h +: 64]
//   mtime          current mtime
//   mtip           registered (mtime >= mtimecmp[h])
module aclint_mtimer #(
    parameter int NUM_HARTS = 1,
    parameter int TICK_DIV  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mtime_we,
    input  logic [63:0]            mtime_wdata,
    input  logic [NUM_HARTS*64-1:0] mtimecmp,
    output logic [63:0]            mtime,
    output logic [NUM_HARTS-1:0]   mtip
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] prescaler;
    logic          tick;

    // With TICK_DIV=1 the prescaler is pinned at 0 and every cycle ticks.
    assign tick = (prescaler == PRE_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prescaler <= '0;
            mtime     <= '0;
        end else if (mtime_we) begin
            prescaler <= '0;
            mtime     <= mtime_wdata;
        end else if (tick) begin
            prescaler <= '0;
            mtime     <= mtime + 64'd1;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtip <= '0;
        end else begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                mtip[h] <= (mtime >= mtimecmp[64*h +: 64]);
            end
        end
    end

endmodule

// File: rtl/aclint_nhart.sv
// aclint_nhart: multi-hart ACLINT (MSIP, MTIMECMP, MTIME, SETSSIP) on a
// valid/ready request bus with a single registered response slot.
//   clk, rst                      clock, async active-low reset
//   req_valid/req_ready           request handshake
//   req_addr/wen/wdata/wmask      byte address, write flag, data, byte enables
//   rsp_valid/rsp_ready/rsp_rdata response handshake and read data (0 on writes)
//   ssip_clr                      per-hart clear from the sip CSR
//   msip, mtip, ssip              per-hart interrupt pending outputs
//   mtime_o                       current mtime for the TIME CSR
module aclint_nhart
    import eei::*;
#(
    parameter int              NUM_HARTS = 1,
    parameter int              TICK_DIV  = 1,
    parameter logic [XLEN-1:0] BASE      = MMAP_ACLINT_BEGIN
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [XLEN-1:0]      req_addr,
    input  logic                 req_wen,
    input  logic [63:0]          req_wdata,
    input  logic [7:0]           req_wmask,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [63:0]          rsp_rdata,
    input  logic [NUM_HARTS-1:0] ssip_clr,
    output logic [NUM_HARTS-1:0] msip,
    output logic [NUM_HARTS-1:0] mtip,
    output logic [NUM_HARTS-1:0] ssip,
    output logic [63:0]          mtime_o
);

    logic [XLEN-1:0]         off;
    logic                    accept;
    logic                    wr;
    logic [63:0]             wmask64;
    aclint_reg_e             reg_sel;
    logic [NUM_HARTS-1:0]    msip_hit;
    logic [NUM_HARTS-1:0]    ssip_hit;
    logic [NUM_HARTS-1:0]    cmp_hit;
    logic                    mtime_hit;
    logic [NUM_HARTS-1:0]    ssip_set;
    logic [63:0]             rd_data;
    logic [63:0]             mtimecmp [NUM_HARTS];
    logic [NUM_HARTS*64-1:0] mtimecmp_flat;
    logic                    mtime_we;
    logic [63:0]             mtime_wdata;

    assign off       = req_addr - BASE;
    assign req_ready = !rsp_valid || rsp_ready;
    assign accept    = req_valid && req_ready;
    assign wr        = accept && req_wen;
    assign wmask64   = byte_mask(req_wmask);

    // 32-bit per-hart registers are packed two per 64-bit beat: hart h lives
    // in the beat at 8*(h/2), lower lane for even h, upper lane for odd h.
    always_comb begin
        msip_hit = '0;
        ssip_hit = '0;
        cmp_hit  = '0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            msip_hit[h] = (off == MMAP_ACLINT_MSIP + XLEN'(8 * (h / 2)));
            ssip_hit[h] = (off == MMAP_ACLINT_SETSSIP + XLEN'(8 * (h / 2)));
            cmp_hit[h]  = (off == MMAP_ACLINT_MTIMECMP + XLEN'(8 * h));
        end
        mtime_hit = (off == MMAP_ACLINT_MTIME);
    end

    always_comb begin
        reg_sel = NONE_R;
        if (|msip_hit)      reg_sel = MSIP_R;
        else if (|cmp_hit)  reg_sel = MTIMECMP_R;
        else if (mtime_hit) reg_sel = MTIME_R;
        else if (|ssip_hit) reg_sel = SETSSIP_R;
    end

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            MSIP_R: begin
                for (int h = 0; h < NUM_HARTS; h++) begin
                    if (msip_hit[h]) rd_data[32 * (h % 2)] = msip[h];
                end
            end
            MTIMECMP_R: begin
                for (int h = 0; h < NUM_HARTS; h++) begin
                    if (cmp_hit[h]) rd_data = mtimecmp[h];
                end
            end
            MTIME_R: rd_data = mtime_o;
            default: rd_data = '0;
        endcase
    end

    always_comb begin
        ssip_set = '0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            ssip_set[h] = wr && (reg_sel == SETSSIP_R) && ssip_hit[h]
                          && req_wmask[4 * (h % 2)] && req_wdata[32 * (h % 2)];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            msip <= '0;
            ssip <= '0;
            for (int h = 0; h < NUM_HARTS; h++) begin
                mtimecmp[h] <= '1;
            end
        end else begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                if (wr && (reg_sel == MSIP_R) && msip_hit[h] && req_wmask[4 * (h % 2)]) begin
                    msip[h] <= req_wdata[32 * (h % 2)];
                end
                // A same-cycle set beats the CSR-side clear so no request is lost.
                if (ssip_set[h]) begin
                    ssip[h] <= 1'b1;
                end else if (ssip_clr[h]) begin
                    ssip[h] <= 1'b0;
                end
                if (wr && (reg_sel == MTIMECMP_R) && cmp_hit[h]) begin
                    mtimecmp[h] <= (mtimecmp[h] & ~wmask64) | (req_wdata & wmask64);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= req_wen ? 64'd0 : rd_data;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end
    end

    always_comb begin
        for (int h = 0; h < NUM_HARTS; h++) begin
            mtimecmp_flat[64*h +: 64] = mtimecmp[h];
        end
    end

    assign mtime_we    = wr && (reg_sel == MTIME_R);
    assign mtime_wdata = (mtime_o & ~wmask64) | (req_wdata & wmask64);

    aclint_mtimer #(
        .NUM_HARTS (NUM_HARTS),
        .TICK_DIV  (TICK_DIV)
    ) u_mtimer (
        .clk         (clk),
        .rst         (rst),
        .mtime_we    (mtime_we),
        .mtime_wdata (mtime_wdata),
        .mtimecmp    (mtimecmp_flat),
        .mtime       (mtime_o),
        .mtip        (mtip)
    );

endmodule

// File: tb/tb_aclint_nhart.sv
// Testbench for aclint_nhart: two instances share one bus, TICK_DIV=1 (dut)
// and TICK_DIV=4 (dut4). Responses are scored against a queue of expected
// read data; mtime/mtip are tracked by a small cycle model.
module tb_aclint_nhart;
    import eei::*;

    localparam int NH = 2;
    localparam logic [31:0] A_MSIP  = MMAP_ACLINT_BEGIN;
    localparam logic [31:0] A_CMP0  = MMAP_ACLINT_BEGIN + 32'h4000;
    localparam logic [31:0] A_CMP1  = MMAP_ACLINT_BEGIN + 32'h4008;
    localparam logic [31:0] A_MTIME = MMAP_ACLINT_BEGIN + 32'h7ff8;
    localparam logic [31:0] A_SSIP  = MMAP_ACLINT_BEGIN + 32'h8000;
    localparam logic [31:0] A_NONE  = MMAP_ACLINT_BEGIN + 32'h5000;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_wen = 1'b0;
    logic [31:0]   req_addr = '0;
    logic [63:0]   req_wdata = '0;
    logic [7:0]    req_wmask = '0;
    logic          rsp_ready = 1'b1;
    logic [NH-1:0] ssip_clr = '0;

    logic          req_ready, rsp_valid;
    logic [63:0]   rsp_rdata, mtime_o;
    logic [NH-1:0] msip, mtip, ssip;
    logic          req_ready_4, rsp_valid_4;
    logic [63:0]   rsp_rdata_4, mtime_o_4;
    logic [NH-1:0] msip_4, mtip_4, ssip_4;

    always #5 clk = ~clk;

    aclint_nhart #(.NUM_HARTS(NH), .TICK_DIV(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_wen(req_wen), .req_wdata(req_wdata),
        .req_wmask(req_wmask), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .ssip_clr(ssip_clr), .msip(msip), .mtip(mtip),
        .ssip(ssip), .mtime_o(mtime_o)
    );

    aclint_nhart #(.NUM_HARTS(NH), .TICK_DIV(4)) dut4 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_4),
        .req_addr(req_addr), .req_wen(req_wen), .req_wdata(req_wdata),
        .req_wmask(req_wmask), .rsp_valid(rsp_valid_4), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata_4), .ssip_clr(ssip_clr), .msip(msip_4), .mtip(mtip_4),
        .ssip(ssip_4), .mtime_o(mtime_o_4)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [63:0] exp_q[$];
    string       name_q[$];

    logic [63:0] m_mtime, m_mtime4;
    int          m_pre4;
    logic [63:0] m_cmp [NH];
    logic [NH-1:0] m_mtip;
    logic        m_rsp_valid;

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd,
                                          input logic [7:0] m);
        logic [63:0] r;
        r = old;
        for (int i = 0; i < 8; i++) if (m[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    task automatic model_reset();
        m_mtime = '0;
        m_mtime4 = '0;
        m_pre4 = 0;
        for (int h = 0; h < NH; h++) m_cmp[h] = '1;
        m_mtip = '0;
        m_rsp_valid = 1'b0;
        exp_q.delete();
        name_q.delete();
    endtask

    // One clock: retire a consumed response from the scoreboard, advance the
    // timer model, then compare mtime/mtip after the edge.
    task automatic step();
        logic          acc;
        logic [63:0]   e;
        string         nm;
        logic [NH-1:0] nxt_mtip;
        acc = req_valid && (!m_rsp_valid || rsp_ready);
        if (m_rsp_valid && rsp_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL scoreboard_empty: rsp_valid=%b rdata=%h with nothing expected",
                         rsp_valid, rsp_rdata);
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (rsp_valid !== 1'b1 || rsp_rdata !== e) begin
                    n_err++;
                    $display("FAIL %s: got valid=%b rdata=%h, want valid=1 rdata=%h",
                             nm, rsp_valid, rsp_rdata, e);
                end
            end
        end
        for (int h = 0; h < NH; h++) nxt_mtip[h] = (m_mtime >= m_cmp[h]);
        if (acc && req_wen && req_addr == A_MTIME) begin
            m_mtime  = merge(m_mtime, req_wdata, req_wmask);
            m_mtime4 = merge(m_mtime4, req_wdata, req_wmask);
            m_pre4   = 0;
        end else begin
            m_mtime = m_mtime + 64'd1;
            if (m_pre4 == 3) begin
                m_pre4 = 0;
                m_mtime4 = m_mtime4 + 64'd1;
            end else begin
                m_pre4++;
            end
        end
        for (int h = 0; h < NH; h++)
            if (acc && req_wen && req_addr == A_CMP0 + 32'(8 * h))
                m_cmp[h] = merge(m_cmp[h], req_wdata, req_wmask);
        if (acc) m_rsp_valid = 1'b1;
        else if (rsp_ready) m_rsp_valid = 1'b0;
        @(posedge clk);
        #1;
        m_mtip = nxt_mtip;
        n_vec++;
        if (mtime_o !== m_mtime || mtime_o_4 !== m_mtime4 || mtip !== m_mtip) begin
            n_err++;
            $display("FAIL timer_track: got mtime=%h mtime4=%h mtip=%b, want %h %h %b",
                     mtime_o, mtime_o_4, mtip, m_mtime, m_mtime4, m_mtip);
        end
    endtask

    task automatic drive(input logic wen, input logic [31:0] addr, input logic [63:0] wd,
                         input logic [7:0] m, input logic [63:0] exp_rd, input string nm);
        req_valid = 1'b1;
        req_wen   = wen;
        req_addr  = addr;
        req_wdata = wd;
        req_wmask = m;
        exp_q.push_back(wen ? 64'd0 : exp_rd);
        name_q.push_back(nm);
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_wen   = 1'b0;
        req_wmask = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
        n_vec++; if (rsp_rdata !== 64'd0) begin n_err++; $display("FAIL rst_rsp_rdata: got %h want 0", rsp_rdata); end
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
        n_vec++; if (msip !== 2'b00) begin n_err++; $display("FAIL rst_msip: got %b want 00", msip); end
        n_vec++; if (ssip !== 2'b00) begin n_err++; $display("FAIL rst_ssip: got %b want 00", ssip); end
        n_vec++; if (mtip !== 2'b00) begin n_err++; $display("FAIL rst_mtip: got %b want 00", mtip); end
        n_vec++; if (mtime_o !== 64'd0 || mtime_o_4 !== 64'd0) begin
            n_err++; $display("FAIL rst_mtime: got %h/%h want 0", mtime_o, mtime_o_4);
        end
        model_reset();
        rst = 1'b1;
        repeat (5) step();
        drive(1'b0, A_MTIME, '0, '0, m_mtime, "rd_mtime");
        step();
        idle();
        step();
        n_vec++; if (mtip !== 2'b00) begin n_err++; $display("FAIL mtip_idle: got %b want 00", mtip); end
    endtask

    task automatic test_mtimecmp();
        logic [63:0] c;
        c = m_mtime + 64'd5;
        drive(1'b1, A_CMP1, c, 8'hFF, '0, "wr_cmp1");
        step();
        idle();
        repeat (8) step();
        n_vec++; if (mtip !== 2'b10) begin n_err++; $display("FAIL mtip_rise: got %b want 10", mtip); end
        drive(1'b1, A_CMP1, '1, 8'hFF, '0, "wr_cmp1_max");
        step();
        idle();
        n_vec++; if (mtip !== 2'b10) begin n_err++; $display("FAIL mtip_hold: got %b want 10", mtip); end
        step();
        n_vec++; if (mtip !== 2'b00) begin n_err++; $display("FAIL mtip_fall: got %b want 00", mtip); end
    endtask

    task automatic test_tick_div();
        repeat (8) step();
        drive(1'b1, A_MTIME, '1, 8'hFF, '0, "wr_mtime_max");
        step();
        idle();
        n_vec++; if (mtime_o_4 !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            n_err++; $display("FAIL mtime4_load: got %h want ffffffffffffffff", mtime_o_4);
        end
        repeat (3) step();
        n_vec++; if (mtime_o_4 !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            n_err++; $display("FAIL mtime4_hold: got %h want ffffffffffffffff", mtime_o_4);
        end
        step();
        n_vec++; if (mtime_o_4 !== 64'd0) begin n_err++; $display("FAIL mtime4_wrap: got %h want 0", mtime_o_4); end
        for (int i = 0; i < 4 && m_pre4 != 3; i++) step();
        drive(1'b1, A_MTIME, 64'h1234, 8'hFF, '0, "wr_mtime_tick");
        step();
        idle();
        n_vec++; if (mtime_o_4 !== 64'h1234 || mtime_o !== 64'h1234) begin
            n_err++; $display("FAIL mtime_write_wins: got %h/%h want 1234", mtime_o, mtime_o_4);
        end
    endtask

    task automatic test_msip();
        drive(1'b1, A_MSIP, 64'h0000_0001_0000_0000, 8'hF0, '0, "wr_msip1");
        step();
        idle();
        n_vec++; if (msip !== 2'b10) begin n_err++; $display("FAIL msip_hart1: got %b want 10", msip); end
        drive(1'b0, A_MSIP, '0, '0, 64'h0000_0001_0000_0000, "rd_msip_10");
        step();
        drive(1'b1, A_MSIP, '1, 8'h0F, '0, "wr_msip0");
        step();
        n_vec++; if (msip !== 2'b11) begin n_err++; $display("FAIL msip_lane0: got %b want 11", msip); end
        drive(1'b0, A_MSIP, '0, '0, 64'h0000_0001_0000_0001, "rd_msip_11");
        step();
        drive(1'b1, A_MSIP, 64'h0000_0000_FFFF_FFFF, 8'hF0, '0, "wr_msip1_clr");
        step();
        idle();
        n_vec++; if (msip !== 2'b01) begin n_err++; $display("FAIL msip_lane1_clr: got %b want 01", msip); end
        step();
    endtask

    task automatic test_ssip();
        ssip_clr = 2'b01;
        drive(1'b1, A_SSIP, 64'h1, 8'h01, '0, "wr_setssip0");
        step();
        idle();
        n_vec++; if (ssip !== 2'b01) begin n_err++; $display("FAIL ssip_set_wins: got %b want 01", ssip); end
        step();
        ssip_clr = 2'b00;
        n_vec++; if (ssip !== 2'b00) begin n_err++; $display("FAIL ssip_clr: got %b want 00", ssip); end
        drive(1'b0, A_SSIP, '0, '0, 64'd0, "rd_setssip");
        step();
        drive(1'b1, A_SSIP, 64'h0000_0001_0000_0000, 8'h10, '0, "wr_setssip1");
        step();
        idle();
        n_vec++; if (ssip !== 2'b10) begin n_err++; $display("FAIL ssip_hart1: got %b want 10", ssip); end
        ssip_clr = 2'b10;
        step();
        ssip_clr = 2'b00;
        n_vec++; if (ssip !== 2'b00) begin n_err++; $display("FAIL ssip_clr1: got %b want 00", ssip); end
    endtask

    task automatic test_back_to_back();
        drive(1'b0, A_CMP1, '0, '0, m_cmp[1], "b2b_rd_cmp1");
        step();
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready0: got %b want 1", req_ready); end
        drive(1'b1, A_CMP0, 64'h0000_00FF_0000_0000, 8'hF0, '0, "b2b_wr_cmp0");
        step();
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready1: got %b want 1", req_ready); end
        drive(1'b0, A_CMP0, '0, '0, 64'h0000_00FF_FFFF_FFFF, "b2b_rd_cmp0");
        step();
        drive(1'b0, A_NONE, '0, '0, 64'd0, "b2b_rd_unmapped");
        step();
        drive(1'b1, A_NONE, '1, 8'hFF, '0, "b2b_wr_unmapped");
        step();
        idle();
        step();
    endtask

    task automatic test_backpressure();
        drive(1'b0, A_MSIP, '0, '0, 64'h0000_0000_0000_0001, "bp_rd_msip");
        step();
        rsp_ready = 1'b0;
        drive(1'b0, A_NONE, '0, '0, 64'd0, "bp_rd_unmapped");
        for (int i = 0; i < 3; i++) begin
            step();
            n_vec++;
            if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== 64'h1) begin
                n_err++;
                $display("FAIL stall_hold: got ready=%b valid=%b rdata=%h, want 0 1 %h",
                         req_ready, rsp_valid, rsp_rdata, 64'h1);
            end
        end
        rsp_ready = 1'b1;
        step();
        idle();
        step();
    endtask

    task automatic test_reset_mid();
        drive(1'b0, A_MTIME, '0, '0, m_mtime, "rst_mid_rd");
        step();
        idle();
        rsp_ready = 1'b0;
        n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL pre_rst_valid: got %b want 1", rsp_valid); end
        rst = 1'b0;
        #1;
        n_vec++; if (rsp_valid !== 1'b0 || rsp_rdata !== 64'd0) begin
            n_err++; $display("FAIL async_rst_rsp: got valid=%b rdata=%h want 0 0", rsp_valid, rsp_rdata);
        end
        n_vec++; if (mtime_o !== 64'd0 || ssip !== 2'b00 || msip !== 2'b00) begin
            n_err++; $display("FAIL async_rst_state: got mtime=%h msip=%b ssip=%b want 0", mtime_o, msip, ssip);
        end
        model_reset();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_ready: got %b want 1", req_ready); end
        repeat (3) step();
    endtask

    initial begin
        test_reset();
        test_mtimecmp();
        test_tick_div();
        test_msip();
        test_ssip();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/aclint_nhart.md
Name: aclint_nhart

Overview:
- Parametrised ACLINT device generalising the single-hart MSIP/MTIMECMP/MTIME/SETSSIP map in package eei to NUM_HARTS harts.
- Adds a programmable mtime prescaler, byte-masked 64-bit writes, a response register with back-pressure, and per-hart supervisor software-interrupt pending bits.
- Sits on the memory bus behind the address decoder, at eei::MMAP_ACLINT_BEGIN. Drives msip/mtip/ssip to each hart's CSR unit.

Parameters:
- NUM_HARTS, 1, number of harts served; range 1..32.
- TICK_DIV, 1, core clocks per mtime increment; must be >=1.
- BASE, eei::MMAP_ACLINT_BEGIN, bus base address.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- req_valid  input  1  bus request valid
- req_ready  output  1  request accepted when req_valid && req_ready
- req_addr  input  XLEN  byte address, 8-byte aligned
- req_wen  input  1  1=write, 0=read
- req_wdata  input  64  write data
- req_wmask  input  8  byte enables
- rsp_valid  output  1  read/write response valid
- rsp_ready  input  1  response consumed
- rsp_rdata  output  64  read data; 0 for writes
- ssip_clr  input  NUM_HARTS  per-hart clear from sip CSR write
- msip  output  NUM_HARTS  machine software interrupt pending
- mtip  output  NUM_HARTS  machine timer interrupt pending
- ssip  output  NUM_HARTS  supervisor software interrupt pending
- mtime_o  output  64  current mtime, for the TIME CSR

Behaviour:
- Reset values: mtime=0, prescaler=0, mtimecmp[h]=all ones, msip=0, ssip=0, mtip=0, rsp_valid=0, rsp_rdata=0. req_ready=1 after reset.
- Handshake:
  - req_ready = !rsp_valid || rsp_ready.
  - Accepted request yields rsp_valid exactly 1 cycle later.
  - rsp_valid and rsp_rdata hold stable until rsp_ready.
  - Back-to-back requests run at 1 per cycle while rsp_ready=1.
- Address decode: off = req_addr - BASE.
  - MSIP: off in [0, 4*NUM_HARTS). 32-bit word per hart h at off=4h; lane is addr[2]. Only bit 0 is stored; other bits read 0.
  - MTIMECMP: off = 0x4000 + 8h, full 64-bit.
  - MTIME: off = 0x7ff8.
  - SETSSIP: off = 0x8000 + 4h. Reads return 0. A write with bit 0=1 in the selected lane sets ssip[h].
  - Any other offset: reads return 0, writes are ignored, and the response is still issued.
- Byte masking: only enabled bytes update. For 32-bit registers, the enables of the addressed lane apply.
- mtime:
  - The prescaler counts 0..TICK_DIV-1. mtime increments on the cycle the prescaler wraps. TICK_DIV=1 means increment every cycle.
  - mtime wraps 2^64-1 -> 0 with no flag.
  - A bus write to MTIME takes precedence over the increment in the same cycle and clears the prescaler.
- mtip[h] is registered: mtip[h] <= (mtime >= mtimecmp[h]), unsigned compare. It reflects a register update 1 cycle after that update.
  - After reset, mtip stays 0 because mtimecmp is all ones.
  - Writing mtimecmp below mtime raises mtip next cycle.
  - Writing mtimecmp above mtime drops mtip next cycle.
- ssip: if a SETSSIP write and ssip_clr[h] hit the same cycle, set wins.
- Reads return values at request acceptance, i.e. before any same-cycle update.
- Reset asserted mid-transaction: outstanding response is discarded (rsp_valid=0); all state takes reset values asynchronously.

Decomposition:
- Add to eei: MMAP_ACLINT_MSIP/MTIMECMP/MTIME/SETSSIP offsets (already present), ACLINT_MAX_HARTS=32, and an AclintReg enum {MSIP_R, MTIMECMP_R, MTIME_R, SETSSIP_R, NONE_R} for decode.
- Sub-module aclint_mtimer: prescaler, mtime register, NUM_HARTS comparators, with a write port for mtime and mtime_o out.
- Top level holds bus decode, msip/ssip/mtimecmp registers and the response register.

Test Plan:
- Reset, NUM_HARTS=2, TICK_DIV=1 -> mtime_o increments every cycle; read MTIME returns the value at acceptance; mtip=2'b00.
- Write mtimecmp[1]=mtime+5 (wmask=0xFF) -> mtip[1] rises the cycle after mtime reaches cmp; mtip[0] stays 0. Then write mtimecmp[1]=all ones -> mtip[1] falls next cycle.
- TICK_DIV=4 -> mtime increments once per 4 cycles. Write MTIME=0xFFFF_FFFF_FFFF_FFFF -> after 4 cycles it wraps to 0. Write coinciding with a tick -> written value wins.
- Write 0x0000_0001_0000_0000 wmask=0xF0 to off 0x0 (hart1 lane) -> msip=2'b10. Read off 0x0 -> rdata=0x0000_0001_0000_0000.
- SETSSIP write to hart0 in the same cycle as ssip_clr[0]=1 -> ssip[0]=1. Next cycle ssip_clr[0]=1 alone -> ssip[0]=0. Read 0x8000 -> 0.
- Hold rsp_ready=0 for 3 cycles after a read -> req_ready=0, rsp_rdata stable. Read of unmapped off 0x5000 -> rdata=0, response issued. Reset asserted with rsp_valid=1 -> rsp_valid=0 immediately.
